mem_io_responder: RTL and testbench

Memory-side responder for the `ARM` core's data port: decodes the core's byte address, serves word reads and writes to a data RAM, and exposes memory-mapped I/O. I/O comprises an LED register, DIP-switch input, a free-running cycle counter and a character transmit FIFO with a valid/ready drain port. It sits beside the core in the top-level wrapper and drives `ReadData` back to the core in the same cycle the address is presented.

---
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Data-port responder for the ARM core: word RAM, LED/DIP I/O,
//               cycle counter and a byte TX FIFO with valid/ready drain.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int DATA_DEPTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [15:0] DIP,
    output logic [7:0]  LED,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady
);

    localparam int c_ramAw = $clog2(DATA_DEPTH);
    localparam int c_ptrW  = $clog2(FIFO_DEPTH);

    localparam logic [29:0]       c_ramBase    = 30'h200;
    localparam logic [29:0]       c_ramWords   = 30'(DATA_DEPTH);
    localparam logic [29:0]       c_ledWord    = 30'h300;
    localparam logic [29:0]       c_dipWord    = 30'h301;
    localparam logic [29:0]       c_cycWord    = 30'h302;
    localparam logic [29:0]       c_txDataWord = 30'h303;
    localparam logic [29:0]       c_txStatWord = 30'h304;
    localparam logic [c_ptrW-1:0] c_ptrOne     = 1;
    localparam logic [c_ptrW:0]   c_cntOne     = 1;
    localparam logic [c_ptrW:0]   c_fifoFull   = (c_ptrW+1)'(FIFO_DEPTH);

    logic [31:0]        r_ram [DATA_DEPTH];
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [7:0]         r_led;
    logic [31:0]        r_cycles;
    logic [c_ptrW-1:0]  r_wrPtr;
    logic [c_ptrW-1:0]  r_rdPtr;
    logic [c_ptrW:0]    r_count;
    logic               r_ovf;

    logic [29:0]        w_word;
    logic [29:0]        w_ramOff;
    logic [c_ramAw-1:0] w_ramIdx;
    logic               w_ramHit;
    logic               w_wrEn;
    logic               w_push;
    logic               w_pop;
    logic               w_doPush;
    logic               w_full;
    logic               w_empty;
    logic [31:0]        w_txStat;
    logic               w_unused;

    assign w_word   = Addr[31:2];
    // Addresses below the RAM base wrap to a huge offset, so one compare decodes the range.
    assign w_ramOff = w_word - c_ramBase;
    assign w_ramHit = (w_ramOff < c_ramWords);
    assign w_ramIdx = w_ramOff[c_ramAw-1:0];
    assign w_unused = &{1'b0, Addr[1:0]};

    assign w_wrEn   = MemWrite && !Reset;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_fifoFull);
    assign w_push   = w_wrEn && (w_word == c_txDataWord);
    assign w_pop    = !w_empty && TxReady && !Reset;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_doPush = w_push && (!w_full || w_pop);

    assign w_txStat = {24'b0, 4'(r_count), 1'b0, r_ovf, w_full, w_empty};

    assign LED     = r_led;
    assign TxData  = r_fifo[r_rdPtr];
    assign TxValid = !w_empty;

    always_ff @(posedge CLK) begin
        if (w_wrEn && w_ramHit) begin
            r_ram[w_ramIdx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_doPush) begin
            r_fifo[r_wrPtr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_led    <= '0;
            r_cycles <= '0;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wrEn && (w_word == c_ledWord)) begin
                r_led <= WriteData[7:0];
            end
            r_cycles <= (w_wrEn && (w_word == c_cycWord)) ? 32'd0 : r_cycles + 32'd1;
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_ptrOne;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_ptrOne;
            end
            if (w_doPush && !w_pop) begin
                r_count <= r_count + c_cntOne;
            end else if (!w_doPush && w_pop) begin
                r_count <= r_count - c_cntOne;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wrEn && (w_word == c_txStatWord) && WriteData[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (w_ramHit) begin
            ReadData = r_ram[w_ramIdx];
        end else if (w_word == c_ledWord) begin
            ReadData = {24'b0, r_led};
        end else if (w_word == c_dipWord) begin
            ReadData = {16'b0, DIP};
        end else if (w_word == c_cycWord) begin
            ReadData = r_cycles;
        end else if (w_word == c_txDataWord) begin
            ReadData = {24'b0, TxData};
        end else if (w_word == c_txStatWord) begin
            ReadData = w_txStat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Directed and randomized bench for mem_io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    localparam int DATA_DEPTH = 128;
    localparam int FIFO_DEPTH = 4;

    logic        CLK;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] DIP;
    logic [7:0]  LED;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    int nChecks = 0;
    int nFail   = 0;

    logic [31:0] mRam [DATA_DEPTH];
    bit          mKnown [DATA_DEPTH];
    logic [7:0]  mLed;
    logic [31:0] mCycles;
    logic [7:0]  mFifo [$];
    bit          mOvf;

    mem_io_responder #(.DATA_DEPTH(DATA_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .DIP(DIP), .LED(LED),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit isRam(input logic [31:0] a);
        int w = int'(a[31:2]);
        return (w >= 'h200) && (w < 'h200 + DATA_DEPTH);
    endfunction

    // Returns 1 when the expected read value is defined.
    function automatic bit modelRead(input logic [31:0] a, output logic [31:0] v);
        int w = int'(a[31:2]);
        int n = mFifo.size();
        v = 32'd0;
        if (isRam(a)) begin
            v = mRam[w - 'h200];
            return mKnown[w - 'h200];
        end
        case (w)
            'h300: v = {24'b0, mLed};
            'h301: v = {16'b0, DIP};
            'h302: v = mCycles;
            'h303: begin
                if (n == 0) return 1'b0;
                v = {24'b0, mFifo[0]};
            end
            'h304: v = {24'b0, 4'(n), 1'b0, mOvf, n == FIFO_DEPTH, n == 0};
            default: v = 32'd0;
        endcase
        return 1'b1;
    endfunction

    task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] wd,
                        input bit rdy, input bit rst, input bit chk,
                        input string tag, input bit useExp, input logic [31:0] exp);
        logic [31:0] mv;
        bit known, pop, wasFull;
        int w;
        @(negedge CLK);
        MemWrite = mw; Addr = a; WriteData = wd; TxReady = rdy; Reset = rst;
        #1;
        if (chk) begin
            known = modelRead(a, mv);
            if (known) checkValue("rdata", ReadData, mv);
            checkValue("led", {24'b0, LED}, {24'b0, mLed});
            checkValue("txvalid", {31'b0, TxValid}, {31'b0, mFifo.size() != 0});
            if (mFifo.size() != 0) checkValue("txdata", {24'b0, TxData}, {24'b0, mFifo[0]});
        end
        if (useExp) checkValue(tag, ReadData, exp);
        @(posedge CLK);
        if (rst) begin
            mLed = 8'd0; mCycles = 32'd0; mFifo.delete(); mOvf = 1'b0;
        end else begin
            w       = int'(a[31:2]);
            pop     = (mFifo.size() != 0) && rdy;
            wasFull = (mFifo.size() == FIFO_DEPTH);
            mCycles = (mw && w == 'h302) ? 32'd0 : mCycles + 32'd1;
            if (pop) void'(mFifo.pop_front());
            if (mw) begin
                if (isRam(a)) begin
                    mRam[w - 'h200]   = wd;
                    mKnown[w - 'h200] = 1'b1;
                end
                if (w == 'h300) mLed = wd[7:0];
                if (w == 'h303) begin
                    if (!wasFull || pop) mFifo.push_back(wd[7:0]);
                    else mOvf = 1'b1;
                end
                if (w == 'h304 && wd[2]) mOvf = 1'b0;
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        step(1'b1, a, wd, rdy, 1'b0, 1'b1, "", 1'b0, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit rdy);
        step(1'b0, a, 32'd0, rdy, 1'b0, 1'b1, tag, 1'b1, exp);
    endtask

    task automatic doReset(input bit chk);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, chk, "", 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  b;
        Reset = 1'b1; MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0;
        DIP = 16'd0; TxReady = 1'b0;

        doReset(1'b0);
        doReset(1'b0);
        #1;
        checkValue("led_reset", {24'b0, LED}, 32'd0);
        checkValue("txvalid_reset", {31'b0, TxValid}, 32'd0);

        for (int i = 0; i < DATA_DEPTH; i++) wr(32'h800 + 32'(4 * i), 32'd0, 1'b0);

        wr(32'h804, 32'hDEADBEEF, 1'b0);
        wr(32'h8FC, 32'h12345678, 1'b0);
        rd("ram_804", 32'h804, 32'hDEADBEEF, 1'b0);
        rd("ram_8fc", 32'h8FE, 32'h12345678, 1'b0);
        rd("ram_800", 32'h800, 32'h0, 1'b0);
        rd("ram_900", 32'h900, 32'h0, 1'b0);

        wr(32'hC00, 32'h1A5, 1'b0);
        #1 checkValue("led_write", {24'b0, LED}, 32'hA5);
        DIP = 16'hBEEF;
        rd("dip_read", 32'hC04, 32'h0000BEEF, 1'b0);
        wr(32'hC04, 32'hFFFF_FFFF, 1'b0);
        rd("dip_ro", 32'hC04, 32'h0000BEEF, 1'b0);
        doReset(1'b1);
        #1 checkValue("led_after_reset", {24'b0, LED}, 32'd0);

        for (int i = 0; i < 5; i++) rd("idle", 32'd0, 32'd0, 1'b0);
        rd("cycles_5", 32'hC08, 32'd5, 1'b0);
        wr(32'hC08, 32'h1234, 1'b0);
        rd("cycles_clr", 32'hC08, 32'd0, 1'b0);
        #1;
        force dut.r_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycles;
        mCycles = 32'hFFFF_FFFF;
        rd("cycles_max", 32'hC08, 32'hFFFF_FFFF, 1'b0);
        rd("cycles_wrap", 32'hC08, 32'd0, 1'b0);

        for (int i = 0; i < 4; i++) wr(32'hC0C, 32'h41 + 32'(i), 1'b0);
        rd("txstat_full", 32'hC10, 32'h42, 1'b0);
        wr(32'hC0C, 32'h45, 1'b0);
        rd("txstat_ovf", 32'hC10, 32'h46, 1'b0);
        wr(32'hC10, 32'h4, 1'b0);
        rd("txstat_clr", 32'hC10, 32'h42, 1'b0);
        for (int i = 0; i < 4; i++) rd("drain", 32'hC0C, 32'h41 + 32'(i), 1'b1);
        rd("txstat_empty", 32'hC10, 32'h01, 1'b1);

        for (int i = 0; i < 4; i++) wr(32'hC0C, 32'h41 + 32'(i), 1'b0);
        wr(32'hC0C, 32'h55, 1'b1);
        rd("full_push_pop", 32'hC10, 32'h42, 1'b0);
        rd("drain_pp0", 32'hC0C, 32'h42, 1'b1);
        rd("drain_pp1", 32'hC0C, 32'h43, 1'b1);
        rd("drain_pp2", 32'hC0C, 32'h44, 1'b1);
        rd("drain_pp3", 32'hC0C, 32'h55, 1'b1);
        rd("txstat_pp_empty", 32'hC10, 32'h01, 1'b1);

        wr(32'hC0C, 32'h61, 1'b0);
        wr(32'hC0C, 32'h62, 1'b0);
        wr(32'hC0C, 32'h63, 1'b0);
        rd("drain_mid", 32'hC0C, 32'h61, 1'b1);
        step(1'b0, 32'hC0C, 32'd0, 1'b1, 1'b1, 1'b1, "", 1'b0, 32'd0);
        #1 checkValue("txvalid_mid_reset", {31'b0, TxValid}, 32'd0);
        rd("txstat_mid_reset", 32'hC10, 32'h01, 1'b1);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1: a = 32'h800 + 32'(4 * $urandom_range(0, DATA_DEPTH - 1));
                2:    a = 32'hC00;
                3:    a = 32'hC04;
                4:    a = ($urandom_range(0, 7) == 0) ? 32'hC08 : 32'hC04;
                5, 6: a = 32'hC0C;
                7:    a = 32'hC10;
                default: begin
                    case ($urandom_range(0, 5))
                        0: a = 32'h0000_0000;
                        1: a = 32'h0000_0A00;
                        2: a = 32'h0000_0C14;
                        3: a = 32'h0000_07FC;
                        4: a = 32'h8000_0804;
                        default: a = 32'h0000_1C00;
                    endcase
                end
            endcase
            a = a | 32'($urandom_range(0, 3));
            b = 8'($urandom);
            DIP = 16'($urandom);
            step(1'($urandom), a, {24'($urandom), b}, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 63) == 0), 1'b1, "", 1'b0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
